// File: rtl/mc_arm_controller_if.sv
// Control bus between the multicycle ARM controller and its datapath.
// The controller uses the master view; the datapath (or a bench) uses the slave view.
interface mc_arm_controller_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic [3:0]         Rd;
  logic [3:0]         Cond;
  logic [3:0]         ALUFlags;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUControl;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  Op, Funct, Rd, Cond, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, dbg_state
  );

  modport slave (
    output Op, Funct, Rd, Cond, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, dbg_state
  );
endinterface

// File: rtl/mc_arm_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder, condition unit and NZCV flags.
//   state   | meaning
//   FETCH   | read instruction at PC, PC += 4
//   DECODE  | read registers, compute PC+8
//   MEMADR  | compute load/store address
//   MEMRD   | read data memory
//   MEMWB   | write loaded data to register
//   MEMWR   | write data memory
//   EXECR   | ALU op, register operand
//   EXECI   | ALU op, immediate operand
//   ALUWB   | write ALU result to register
//   BRANCH  | write branch target to PC
//   UNKNOWN | unsupported opcode, skipped
module mc_arm_controller #(
  parameter int STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  mc_arm_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic        next_pc, branch, reg_w, mem_w, ir_w, alu_op;
  logic        adr_src, alu_src_a;
  logic [1:0]  result_src, alu_src_b;
  logic [1:0]  alu_ctl, flag_w;
  logic        cond_ex, pcs;
  logic        n_f, z_f, c_f, v_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    result_src = 2'b00;
    alu_src_b  = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_w       = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        unique case (bus.Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_op    = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Unrecognised Funct[4:1] falls back to ADD and never touches the flags.
  always_comb begin
    alu_ctl = 2'b00;
    flag_w  = 2'b00;
    if (alu_op) begin
      unique case (bus.Funct[4:1])
        4'b0100: begin alu_ctl = 2'b00; flag_w = {2{bus.Funct[0]}}; end
        4'b0010: begin alu_ctl = 2'b01; flag_w = {2{bus.Funct[0]}}; end
        4'b0000: begin alu_ctl = 2'b10; flag_w = {bus.Funct[0], 1'b0}; end
        4'b1100: begin alu_ctl = 2'b11; flag_w = {bus.Funct[0], 1'b0}; end
        default: begin alu_ctl = 2'b00; flag_w = 2'b00; end
      endcase
    end
  end

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    unique case (bus.Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~(c_f & ~z_f);
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] && cond_ex) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_w[0] && cond_ex) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  assign pcs = branch | (reg_w & (bus.Rd == 4'hF));

  // Write enables are forced low while reset is held, even though FETCH is the reset state.
  assign bus.PCWrite    = ~reset & (next_pc | (pcs & cond_ex));
  assign bus.RegWrite   = ~reset & reg_w & cond_ex;
  assign bus.MemWrite   = ~reset & mem_w & cond_ex;
  assign bus.IRWrite    = ~reset & ir_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.dbg_state  = STATE_W'(state_q);

endmodule
